hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Parametrised hazard and forwarding controller for the 5-stage RISC-V pipeline. It provides MEM/WB-priority operand forwarding for any number of EX source ports, one-bubble load-use stall detection, a per-register scoreboard for long-latency (multi-cycle) writebacks, and branch-taken flush control. It sits beside the ID/EX pipeline registers and drives the stall and flush inputs of the IF, ID and EX stages.

## Interface
Parameters:
- NUM_SRC, 2, number of register source operands per instruction (EX and ID)
- REG_IDX_W, 5, register index width
- NUM_REGS, 32, architectural register count (= 2**REG_IDX_W)
- CNT_W, 32, perf counter width (used only with HAZARD_PERF_CNT_EN)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- ex_src_idx  in  NUM_SRC x REG_IDX_W  EX-stage source register indices
- ex_src_fwd_ctrl  out  NUM_SRC x forwarding_src_t  per-source forwarding select
- id_src_idx  in  NUM_SRC x REG_IDX_W  ID-stage source indices
- id_src_used  in  NUM_SRC  per-source "operand actually read" flags
- id_reg_wr_idx / id_reg_wr_en  in  REG_IDX_W / 1  ID-stage destination
- ex_reg_wr_idx / ex_reg_wr_en / ex_is_load  in  REG_IDX_W / 1 / 1  EX-stage destination, load flag
- mem_reg_wr_idx / mem_reg_wr_en  in  REG_IDX_W / 1  MEM-stage destination
- wb_reg_wr_idx / wb_reg_wr_en  in  REG_IDX_W / 1  WB-stage destination
- lat_issue / lat_issue_idx  in  1 / REG_IDX_W  ID instruction is a long-latency op writing lat_issue_idx
- lat_done / lat_done_idx  in  1 / REG_IDX_W  long-latency unit completes writeback of lat_done_idx
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- stall_if, stall_id  out  1  hold PC and IF/ID register
- flush_id  out  1  clear IF/ID register
- bubble_ex  out  1  insert NOP into ID/EX register
- sb_pending  out  NUM_REGS  registered scoreboard vector
- load_use_stall_cnt, sb_stall_cnt, flush_cnt  out  CNT_W  perf counters (ports present only with HAZARD_PERF_CNT_EN)

## Operation
- Forwarding (combinational, per source i): FWD_SRC_MEM if mem_reg_wr_en, mem_reg_wr_idx == ex_src_idx[i], and index != 0; else FWD_SRC_WB under the same rule for WB; else FWD_SRC_ID. MEM always beats WB. x0 never forwards.
- Load-use: load_hz = ex_is_load & ex_reg_wr_en & ex_reg_wr_idx != 0 & any i (id_src_used[i] & id_src_idx[i] == ex_reg_wr_idx).
- Scoreboard hazard: sb_hz = any i (id_src_used[i] & sb_pending[id_src_idx[i]]) | (id_reg_wr_en & sb_pending[id_reg_wr_idx]) (RAW plus WAW).
- Branch taken: flush_id = 1, bubble_ex = 1, stall_if = stall_id = 0; flush overrides all stalls.
- Otherwise, hz = load_hz | sb_hz: stall_if = stall_id = bubble_ex = hz; flush_id = 0.
- Scoreboard update, on accepted issue only (lat_issue & ~stall_id & ~ex_branch_taken & lat_issue_idx != 0): set bit. On lat_done: clear bit lat_done_idx. Same index set and clear in one cycle: set wins. lat_done on a clear bit: no effect. Index 0 is never set.

## Timing
- Forwarding, stall, flush and bubble outputs: combinational, zero latency.
- sb_pending: registered; a set becomes visible the cycle after issue, a clear the cycle after lat_done. Stall therefore releases one cycle after completion; WB forwarding covers the value.
- Load-use stall lasts exactly one cycle; the load has reached MEM on the next cycle.
- Reset (async, any time, including mid-stall): sb_pending = 0 and counters = 0 immediately; combinational outputs follow their inputs with an empty scoreboard.

## Configuration
- HAZARD_PERF_CNT_EN defined: three CNT_W saturating counters, each incremented once per cycle of the corresponding event.
  - load_use_stall_cnt: load_hz & ~ex_branch_taken.
  - sb_stall_cnt: sb_hz & ~load_hz & ~ex_branch_taken.
  - flush_cnt: ex_branch_taken.
  - Counters hold at all-ones.
- Not defined: no counter logic and no counter ports.

## Structure
- forwarding_src_t (FWD_SRC_ID, FWD_SRC_MEM, FWD_SRC_WB) stays in the shared control_types package. Add REG_X0 = 0 there.
- Sub-module hazard_scoreboard (clk, rst, set/set_idx, clr/clr_idx, pending vector) holds all scoreboard state. The top level holds the forwarding, hazard and flush logic and the counters.

## Test plan
- ex_src_idx = {1,2}, MEM wr x3, WB wr x4, both enabled -> both FWD_SRC_ID. Then MEM and WB both write x10 with ex_src_idx[0] = 10 -> FWD_SRC_MEM. Then ex_src_idx[0] = 0 with MEM wr x0 -> FWD_SRC_ID.
- EX load writes x5; ID rs2 = x5 with used = 1 -> stall_if/stall_id/bubble_ex = 1 for one cycle. Same case with used = 0 -> no stall.
- Issue a long-latency op to x7, then ID reads x7 -> stall every cycle until the cycle after lat_done(x7), then released; sb_pending[7] 1 -> 0.
- lat_done(x9) and an accepted lat_issue(x9) in the same cycle -> sb_pending[9] = 1. lat_issue(x0) -> sb_pending unchanged.
- ex_branch_taken coincident with load_hz and lat_issue(x12) -> flush_id = 1, bubble_ex = 1, stalls 0, sb_pending[12] stays 0.
- Assert rst while sb_pending = 0x80 with a stall active -> sb_pending = 0 and stall drops without waiting for a clock edge. With HAZARD_PERF_CNT_EN, counters are also 0.

Source files
------------

// File: rtl/control_types.sv
// Shared pipeline control types: forwarding select encoding and the x0 index.
package control_types;

  typedef enum logic [1:0] {
    FWD_SRC_ID  = 2'd0,
    FWD_SRC_MEM = 2'd1,
    FWD_SRC_WB  = 2'd2
  } forwarding_src_t;

  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending bits for long-latency writebacks; set beats clear on the same index.
module hazard_scoreboard
  import control_types::*;
#(
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr,
  input  logic [REG_IDX_W-1:0] clr_idx,
  output logic [NUM_REGS-1:0]  pending
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr) pending_d[clr_idx] = 1'b0;
    // x0 is hardwired, so it can never own an outstanding write
    if (set && (set_idx != REG_IDX_W'(REG_X0))) pending_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  assign pending = pending_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Forwarding, load-use / scoreboard stall and branch flush control for the 5-stage pipeline.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit
  import control_types::*;
#(
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned REG_IDX_W = 5,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC-1:0][REG_IDX_W-1:0]   ex_src_idx,
  output forwarding_src_t [NUM_SRC-1:0]       ex_src_fwd_ctrl,
  input  logic [NUM_SRC-1:0][REG_IDX_W-1:0]   id_src_idx,
  input  logic [NUM_SRC-1:0]                  id_src_used,
  input  logic [REG_IDX_W-1:0]                id_reg_wr_idx,
  input  logic                                id_reg_wr_en,
  input  logic [REG_IDX_W-1:0]                ex_reg_wr_idx,
  input  logic                                ex_reg_wr_en,
  input  logic                                ex_is_load,
  input  logic [REG_IDX_W-1:0]                mem_reg_wr_idx,
  input  logic                                mem_reg_wr_en,
  input  logic [REG_IDX_W-1:0]                wb_reg_wr_idx,
  input  logic                                wb_reg_wr_en,
  input  logic                                lat_issue,
  input  logic [REG_IDX_W-1:0]                lat_issue_idx,
  input  logic                                lat_done,
  input  logic [REG_IDX_W-1:0]                lat_done_idx,
  input  logic                                ex_branch_taken,
  output logic                                stall_if,
  output logic                                stall_id,
  output logic                                flush_id,
  output logic                                bubble_ex,
  output logic [NUM_REGS-1:0]                 sb_pending
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]                    load_use_stall_cnt,
  output logic [CNT_W-1:0]                    sb_stall_cnt,
  output logic [CNT_W-1:0]                    flush_cnt
`endif
);

  localparam logic [REG_IDX_W-1:0] X0 = REG_IDX_W'(REG_X0);

  logic load_hz;
  logic sb_hz;
  logic hz;
  logic issue_ok;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_src_fwd_ctrl[i] = FWD_SRC_ID;
      // MEM is checked last so it overrides an older WB match
      if (wb_reg_wr_en && (wb_reg_wr_idx != X0) && (wb_reg_wr_idx == ex_src_idx[i]))
        ex_src_fwd_ctrl[i] = FWD_SRC_WB;
      if (mem_reg_wr_en && (mem_reg_wr_idx != X0) && (mem_reg_wr_idx == ex_src_idx[i]))
        ex_src_fwd_ctrl[i] = FWD_SRC_MEM;
    end
  end

  always_comb begin
    load_hz = 1'b0;
    sb_hz   = id_reg_wr_en && sb_pending[id_reg_wr_idx];
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_used[i] && (id_src_idx[i] == ex_reg_wr_idx)) load_hz = 1'b1;
      if (id_src_used[i] && sb_pending[id_src_idx[i]])        sb_hz   = 1'b1;
    end
    load_hz = load_hz && ex_is_load && ex_reg_wr_en && (ex_reg_wr_idx != X0);
    hz      = load_hz || sb_hz;
  end

  always_comb begin
    stall_if  = hz;
    stall_id  = hz;
    bubble_ex = hz;
    flush_id  = 1'b0;
    if (ex_branch_taken) begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      bubble_ex = 1'b1;
      flush_id  = 1'b1;
    end
  end

  assign issue_ok = lat_issue && !stall_id && !ex_branch_taken;

  hazard_scoreboard #(
    .REG_IDX_W (REG_IDX_W),
    .NUM_REGS  (NUM_REGS)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set     (issue_ok),
    .set_idx (lat_issue_idx),
    .clr     (lat_done),
    .clr_idx (lat_done_idx),
    .pending (sb_pending)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

  // Saturating: a counter parked at all-ones stays there
  always_comb begin
    lu_cnt_d = lu_cnt_q;
    sb_cnt_d = sb_cnt_q;
    fl_cnt_d = fl_cnt_q;
    if (load_hz && !ex_branch_taken && (lu_cnt_q != '1))
      lu_cnt_d = lu_cnt_q + CNT_W'(1);
    if (sb_hz && !load_hz && !ex_branch_taken && (sb_cnt_q != '1))
      sb_cnt_d = sb_cnt_q + CNT_W'(1);
    if (ex_branch_taken && (fl_cnt_q != '1))
      fl_cnt_d = fl_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt_q <= '0;
      sb_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      sb_cnt_q <= sb_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign load_use_stall_cnt = lu_cnt_q;
  assign sb_stall_cnt       = sb_cnt_q;
  assign flush_cnt          = fl_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (default or HAZARD_PERF_CNT_EN build).
module tb_hazard_control_unit;
  import control_types::*;

  localparam int NUM_SRC = 2;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_W = 32;

  logic clk, rst;
  logic [NUM_SRC-1:0][REG_IDX_W-1:0] ex_src_idx, id_src_idx;
  forwarding_src_t [NUM_SRC-1:0] ex_src_fwd_ctrl;
  logic [NUM_SRC-1:0] id_src_used;
  logic [REG_IDX_W-1:0] id_reg_wr_idx, ex_reg_wr_idx, mem_reg_wr_idx, wb_reg_wr_idx;
  logic id_reg_wr_en, ex_reg_wr_en, ex_is_load, mem_reg_wr_en, wb_reg_wr_en;
  logic lat_issue, lat_done, ex_branch_taken;
  logic [REG_IDX_W-1:0] lat_issue_idx, lat_done_idx;
  logic stall_if, stall_id, flush_id, bubble_ex;
  logic [NUM_REGS-1:0] sb_pending;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] load_use_stall_cnt, sb_stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hazard_control_unit #(
    .NUM_SRC(NUM_SRC), .REG_IDX_W(REG_IDX_W), .NUM_REGS(NUM_REGS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_src_idx(ex_src_idx), .ex_src_fwd_ctrl(ex_src_fwd_ctrl),
    .id_src_idx(id_src_idx), .id_src_used(id_src_used),
    .id_reg_wr_idx(id_reg_wr_idx), .id_reg_wr_en(id_reg_wr_en),
    .ex_reg_wr_idx(ex_reg_wr_idx), .ex_reg_wr_en(ex_reg_wr_en), .ex_is_load(ex_is_load),
    .mem_reg_wr_idx(mem_reg_wr_idx), .mem_reg_wr_en(mem_reg_wr_en),
    .wb_reg_wr_idx(wb_reg_wr_idx), .wb_reg_wr_en(wb_reg_wr_en),
    .lat_issue(lat_issue), .lat_issue_idx(lat_issue_idx),
    .lat_done(lat_done), .lat_done_idx(lat_done_idx),
    .ex_branch_taken(ex_branch_taken),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .bubble_ex(bubble_ex),
    .sb_pending(sb_pending)
`ifdef HAZARD_PERF_CNT_EN
    , .load_use_stall_cnt(load_use_stall_cnt), .sb_stall_cnt(sb_stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ex_src_idx = '0; id_src_idx = '0; id_src_used = '0;
    id_reg_wr_idx = '0; id_reg_wr_en = 1'b0;
    ex_reg_wr_idx = '0; ex_reg_wr_en = 1'b0; ex_is_load = 1'b0;
    mem_reg_wr_idx = '0; mem_reg_wr_en = 1'b0;
    wb_reg_wr_idx = '0; wb_reg_wr_en = 1'b0;
    lat_issue = 1'b0; lat_issue_idx = '0; lat_done = 1'b0; lat_done_idx = '0;
    ex_branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    n_tests++;
    if (sb_pending !== 32'h0) begin
      n_fail++; $display("FAIL reset_sb: got %h exp %h", sb_pending, 32'h0);
    end
    n_tests++;
    if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b exp 0000", {stall_if, stall_id, bubble_ex, flush_id});
    end
    n_tests++;
    if (ex_src_fwd_ctrl[0] !== FWD_SRC_ID || ex_src_fwd_ctrl[1] !== FWD_SRC_ID) begin
      n_fail++; $display("FAIL reset_fwd: got %0d/%0d exp 0/0", ex_src_fwd_ctrl[0], ex_src_fwd_ctrl[1]);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forwarding();
    ex_src_idx[0] = 5'd1; ex_src_idx[1] = 5'd2;
    mem_reg_wr_en = 1'b1; mem_reg_wr_idx = 5'd3;
    wb_reg_wr_en = 1'b1; wb_reg_wr_idx = 5'd4;
    #1;
    n_tests++;
    if (ex_src_fwd_ctrl[0] !== FWD_SRC_ID || ex_src_fwd_ctrl[1] !== FWD_SRC_ID) begin
      n_fail++; $display("FAIL fwd_nomatch: got %0d/%0d exp 0/0", ex_src_fwd_ctrl[0], ex_src_fwd_ctrl[1]);
    end
    mem_reg_wr_idx = 5'd10; wb_reg_wr_idx = 5'd10; ex_src_idx[0] = 5'd10;
    #1;
    n_tests++;
    if (ex_src_fwd_ctrl[0] !== FWD_SRC_MEM || ex_src_fwd_ctrl[1] !== FWD_SRC_ID) begin
      n_fail++; $display("FAIL fwd_mem_prio: got %0d/%0d exp 1/0", ex_src_fwd_ctrl[0], ex_src_fwd_ctrl[1]);
    end
    wb_reg_wr_idx = 5'd4; ex_src_idx[1] = 5'd4;
    #1;
    n_tests++;
    if (ex_src_fwd_ctrl[0] !== FWD_SRC_MEM || ex_src_fwd_ctrl[1] !== FWD_SRC_WB) begin
      n_fail++; $display("FAIL fwd_wb: got %0d/%0d exp 1/2", ex_src_fwd_ctrl[0], ex_src_fwd_ctrl[1]);
    end
    wb_reg_wr_en = 1'b0;
    #1;
    n_tests++;
    if (ex_src_fwd_ctrl[1] !== FWD_SRC_ID) begin
      n_fail++; $display("FAIL fwd_wb_disabled: got %0d exp 0", ex_src_fwd_ctrl[1]);
    end
    ex_src_idx[0] = 5'd0; mem_reg_wr_idx = 5'd0; wb_reg_wr_en = 1'b1; wb_reg_wr_idx = 5'd0;
    #1;
    n_tests++;
    if (ex_src_fwd_ctrl[0] !== FWD_SRC_ID) begin
      n_fail++; $display("FAIL fwd_x0: got %0d exp 0", ex_src_fwd_ctrl[0]);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_use();
    ex_is_load = 1'b1; ex_reg_wr_en = 1'b1; ex_reg_wr_idx = 5'd5;
    id_src_idx[1] = 5'd5; id_src_used[1] = 1'b1;
    #1;
    n_tests++;
    if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b1110) begin
      n_fail++; $display("FAIL load_use_stall: got %b exp 1110", {stall_if, stall_id, bubble_ex, flush_id});
    end
    tick();
    // load advanced to MEM, bubble now in EX
    ex_is_load = 1'b0; ex_reg_wr_en = 1'b0; ex_reg_wr_idx = '0;
    mem_reg_wr_en = 1'b1; mem_reg_wr_idx = 5'd5;
    #1;
    n_tests++;
    if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin
      n_fail++; $display("FAIL load_use_release: got %b exp 000", {stall_if, stall_id, bubble_ex});
    end
    tick();
    clear_inputs();
    ex_is_load = 1'b1; ex_reg_wr_en = 1'b1; ex_reg_wr_idx = 5'd5;
    id_src_idx[1] = 5'd5; id_src_used[1] = 1'b0;
    #1;
    n_tests++;
    if (stall_id !== 1'b0) begin
      n_fail++; $display("FAIL load_use_unused: got %b exp 0", stall_id);
    end
    ex_reg_wr_idx = 5'd0; id_src_idx[0] = 5'd0; id_src_used[0] = 1'b1;
    #1;
    n_tests++;
    if (stall_id !== 1'b0) begin
      n_fail++; $display("FAIL load_use_x0: got %b exp 0", stall_id);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    lat_issue = 1'b1; lat_issue_idx = 5'd7;
    tick();
    lat_issue = 1'b0;
    id_src_idx[0] = 5'd7; id_src_used[0] = 1'b1;
    #1;
    n_tests++;
    if (sb_pending !== 32'h0000_0080) begin
      n_fail++; $display("FAIL sb_set: got %h exp %h", sb_pending, 32'h0000_0080);
    end
    for (int c = 0; c < 3; c++) begin
      n_tests++;
      if (stall_id !== 1'b1 || stall_if !== 1'b1 || bubble_ex !== 1'b1) begin
        n_fail++; $display("FAIL sb_stall_c%0d: got %b exp 111", c, {stall_if, stall_id, bubble_ex});
      end
      tick();
    end
    lat_done = 1'b1; lat_done_idx = 5'd7;
    #1;
    n_tests++;
    if (stall_id !== 1'b1) begin
      n_fail++; $display("FAIL sb_stall_done_cycle: got %b exp 1", stall_id);
    end
    tick();
    lat_done = 1'b0;
    #1;
    n_tests++;
    if (sb_pending !== 32'h0 || stall_id !== 1'b0) begin
      n_fail++; $display("FAIL sb_release: got sb=%h stall=%b exp sb=0 stall=0", sb_pending, stall_id);
    end
    clear_inputs();
    // WAW: ID writing a pending register must also stall
    lat_issue = 1'b1; lat_issue_idx = 5'd20;
    tick();
    lat_issue = 1'b0; id_reg_wr_en = 1'b1; id_reg_wr_idx = 5'd20;
    #1;
    n_tests++;
    if (stall_id !== 1'b1) begin
      n_fail++; $display("FAIL sb_waw: got %b exp 1", stall_id);
    end
    id_reg_wr_en = 1'b0; lat_done = 1'b1; lat_done_idx = 5'd20;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_set_clear_same_cycle();
    lat_issue = 1'b1; lat_issue_idx = 5'd9; lat_done = 1'b1; lat_done_idx = 5'd9;
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (sb_pending !== 32'h0000_0200) begin
      n_fail++; $display("FAIL sb_set_wins: got %h exp %h", sb_pending, 32'h0000_0200);
    end
    lat_issue = 1'b1; lat_issue_idx = 5'd0;
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (sb_pending !== 32'h0000_0200) begin
      n_fail++; $display("FAIL sb_x0_issue: got %h exp %h", sb_pending, 32'h0000_0200);
    end
    lat_done = 1'b1; lat_done_idx = 5'd9;
    tick();
    tick();
    lat_done = 1'b0;
    #1;
    n_tests++;
    if (sb_pending !== 32'h0) begin
      n_fail++; $display("FAIL sb_done_clear: got %h exp %h", sb_pending, 32'h0);
    end
    tick();
  endtask

  task automatic test_branch_flush();
    ex_is_load = 1'b1; ex_reg_wr_en = 1'b1; ex_reg_wr_idx = 5'd5;
    id_src_idx[0] = 5'd5; id_src_used[0] = 1'b1;
    lat_issue = 1'b1; lat_issue_idx = 5'd12;
    ex_branch_taken = 1'b1;
    #1;
    n_tests++;
    if ({stall_if, stall_id, bubble_ex, flush_id} !== 4'b0011) begin
      n_fail++; $display("FAIL branch_ctrl: got %b exp 0011", {stall_if, stall_id, bubble_ex, flush_id});
    end
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (sb_pending[12] !== 1'b0) begin
      n_fail++; $display("FAIL branch_no_issue: got %b exp 0", sb_pending[12]);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    lat_issue = 1'b1; lat_issue_idx = 5'd7;
    tick();
    lat_issue = 1'b0;
    id_src_idx[1] = 5'd7; id_src_used[1] = 1'b1;
    #1;
    n_tests++;
    if (sb_pending !== 32'h0000_0080 || stall_id !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got sb=%h stall=%b exp sb=00000080 stall=1", sb_pending, stall_id);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (sb_pending !== 32'h0 || stall_id !== 1'b0 || stall_if !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got sb=%h stall=%b exp sb=0 stall=0", sb_pending, stall_id);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_tests++;
    if (load_use_stall_cnt !== '0 || sb_stall_cnt !== '0 || flush_cnt !== '0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d/%0d/%0d exp 0/0/0", load_use_stall_cnt, sb_stall_cnt, flush_cnt);
    end
`endif
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    ex_is_load = 1'b1; ex_reg_wr_en = 1'b1; ex_reg_wr_idx = 5'd3;
    id_src_idx[0] = 5'd3; id_src_used[0] = 1'b1;
    tick();
    ex_branch_taken = 1'b1;
    tick();
    clear_inputs();
    lat_issue = 1'b1; lat_issue_idx = 5'd4;
    tick();
    lat_issue = 1'b0; id_src_idx[0] = 5'd4; id_src_used[0] = 1'b1;
    tick();
    tick();
    clear_inputs();
    #1;
    n_tests++;
    if (load_use_stall_cnt !== 32'd1 || sb_stall_cnt !== 32'd2 || flush_cnt !== 32'd1) begin
      n_fail++; $display("FAIL perf_cnt: got %0d/%0d/%0d exp 1/2/1", load_use_stall_cnt, sb_stall_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_scoreboard();
    test_set_clear_same_cycle();
    test_branch_flush();
    test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
